dm_arbiter: RTL



---
 rtl/dm_arbiter_if.sv | 25 ++
 rtl/dm_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// Requester-side word access port of the data-memory arbiter.
// The master modport is the requester; the slave modport is the arbiter.
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 128-byte data memory.
// Each access runs IDLE -> ACCESS (gnt + one strobe) -> RESP (rvalid/rdata/err).
module dm_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 128
) (
  input  logic              clk,
  input  logic              rst,
  dm_arbiter_if.slave       m0,
  dm_arbiter_if.slave       m1,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_data,
  output logic              dm_MemRead,
  output logic              dm_MemWrite,
  input  logic [DATA_W-1:0] dm_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);

  state_t            state, state_n;
  logic              rr_ptr, rr_n;
  logic              win, win_n;
  logic              we_q, we_n;
  logic              legal_q, legal_n;
  logic              gnt0, gnt0_n, gnt1, gnt1_n;
  logic              rvalid0, rvalid0_n, rvalid1, rvalid1_n;
  logic              err0, err0_n, err1, err1_n;
  logic [DATA_W-1:0] rdata0, rdata0_n, rdata1, rdata1_n;
  logic [ADDR_W-1:0] dm_addr_n;
  logic [DATA_W-1:0] dm_data_n;
  logic              rd_n, wr_n;

  logic              sel;
  logic              sel_we;
  logic              sel_legal;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] word;

  // Full-width unsigned compare so high address bits can never alias into range.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_WORD);
  endfunction

  // Port 1 wins when it is the only requester or when both ask and it is favoured.
  assign sel       = m1.req & (~m0.req | rr_ptr);
  assign sel_we    = sel ? m1.we    : m0.we;
  assign sel_addr  = sel ? m1.addr  : m0.addr;
  assign sel_wdata = sel ? m1.wdata : m0.wdata;
  assign sel_legal = addr_legal(sel_addr);
  assign word      = (legal_q && !we_q) ? dm_rdata : '0;

  always_comb begin
    state_n   = state;
    rr_n      = rr_ptr;
    win_n     = win;
    we_n      = we_q;
    legal_n   = legal_q;
    gnt0_n    = 1'b0;
    gnt1_n    = 1'b0;
    rvalid0_n = 1'b0;
    rvalid1_n = 1'b0;
    err0_n    = 1'b0;
    err1_n    = 1'b0;
    rdata0_n  = '0;
    rdata1_n  = '0;
    dm_addr_n = dm_addr;
    dm_data_n = dm_data;
    rd_n      = 1'b0;
    wr_n      = 1'b0;
    case (state)
      IDLE: begin
        if (m0.req || m1.req) begin
          win_n   = sel;
          we_n    = sel_we;
          legal_n = sel_legal;
          gnt0_n  = ~sel;
          gnt1_n  = sel;
          rr_n    = ~sel;
          state_n = ACCESS;
          // Strobes and bus are registered here so they are live during ACCESS.
          if (sel_legal) begin
            dm_addr_n = sel_addr;
            rd_n      = ~sel_we;
            wr_n      = sel_we;
            if (sel_we) dm_data_n = sel_wdata;
          end
        end
      end
      ACCESS: begin
        state_n = RESP;
        if (win) begin
          rvalid1_n = 1'b1;
          err1_n    = ~legal_q;
          rdata1_n  = word;
        end else begin
          rvalid0_n = 1'b1;
          err0_n    = ~legal_q;
          rdata0_n  = word;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      dm_addr     <= '0;
      dm_data     <= '0;
      dm_MemRead  <= 1'b0;
      dm_MemWrite <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_n;
      gnt0        <= gnt0_n;
      gnt1        <= gnt1_n;
      rvalid0     <= rvalid0_n;
      rvalid1     <= rvalid1_n;
      err0        <= err0_n;
      err1        <= err1_n;
      rdata0      <= rdata0_n;
      rdata1      <= rdata1_n;
      dm_addr     <= dm_addr_n;
      dm_data     <= dm_data_n;
      dm_MemRead  <= rd_n;
      dm_MemWrite <= wr_n;
    end
  end

  always_ff @(posedge clk) begin
    win     <= win_n;
    we_q    <= we_n;
    legal_q <= legal_n;
  end

  assign m0.gnt    = gnt0;
  assign m0.rvalid = rvalid0;
  assign m0.rdata  = rdata0;
  assign m0.err    = err0;
  assign m1.gnt    = gnt1;
  assign m1.rvalid = rvalid1;
  assign m1.rdata  = rdata1;
  assign m1.err    = err1;
endmodule
